// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one Avalon-MM DDR3 master port between the read
// buffer (client 0) and the write-back buffer (client 1). Grants alternate
// round-robin, with one command in flight at a time. A single outstanding read
// is tracked, its data is routed back to the owner, and a read that never
// returns is abandoned and flagged.
module ddr_port_arbiter #(
    parameter int unsigned ADDR_W     = 26,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned RD_TIMEOUT = 1023
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              local_init_done,

    // client 0: read buffer
    input  logic              c0_read,
    input  logic              c0_write,
    input  logic [ADDR_W-1:0] c0_address,
    input  logic [DATA_W-1:0] c0_writedata,
    output logic              c0_wait_request_n,
    output logic [DATA_W-1:0] c0_readdata,
    output logic              c0_readdatavalid,

    // client 1: write-back buffer
    input  logic              c1_read,
    input  logic              c1_write,
    input  logic [ADDR_W-1:0] c1_address,
    input  logic [DATA_W-1:0] c1_writedata,
    output logic              c1_wait_request_n,
    output logic [DATA_W-1:0] c1_readdata,
    output logic              c1_readdatavalid,

    // DDR3 controller AVL slave
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_write,
    output logic [DATA_W-1:0] avl_writedata,
    output logic              avl_burstbegin,
    input  logic              avl_wait_request_n,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_readdatavalid,

    // status
    output logic              grant,
    output logic              busy,
    output logic              rd_timeout_err
);

    localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RD_MAX  = CNT_W'(RD_TIMEOUT);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCmd    = 2'd1,
        StRdWait = 2'd2
    } state_e;

    state_e           state;
    logic             rr_last;
    logic [CNT_W-1:0] rd_cnt;

    logic              req0;
    logic              req1;
    logic              pick;
    logic              pick_wr;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_data;

    // Round-robin choice among the clients requesting this cycle.
    always_comb begin
        req0 = c0_read | c0_write;
        req1 = c1_read | c1_write;
        if (req0 && req1) begin
            pick = ~rr_last;
        end else begin
            pick = req1;
        end
        if (pick) begin
            pick_wr   = c1_write;
            pick_addr = c1_address;
            pick_data = c1_writedata;
        end else begin
            pick_wr   = c0_write;
            pick_addr = c0_address;
            pick_data = c0_writedata;
        end
    end

    // Transaction FSM; every AVL command signal is registered here.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state          <= StIdle;
            grant          <= 1'b0;
            rr_last        <= 1'b1;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_address    <= '0;
            avl_writedata  <= '0;
            rd_cnt         <= '0;
            rd_timeout_err <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (local_init_done && (req0 || req1)) begin
                        grant         <= pick;
                        rr_last       <= pick;
                        avl_address   <= pick_addr;
                        avl_writedata <= pick_data;
                        // A client raising both read and write is serviced as a write.
                        avl_write     <= pick_wr;
                        avl_read      <= ~pick_wr;
                        state         <= StCmd;
                    end
                end
                StCmd: begin
                    if (avl_wait_request_n) begin
                        avl_read  <= 1'b0;
                        avl_write <= 1'b0;
                        if (avl_read) begin
                            rd_cnt <= '0;
                            state  <= StRdWait;
                        end else begin
                            state  <= StIdle;
                        end
                    end
                end
                StRdWait: begin
                    if (avl_readdatavalid) begin
                        state <= StIdle;
                    end else if (rd_cnt == RD_LAST) begin
                        // The read is lost; give the port back and remember it.
                        rd_cnt         <= RD_MAX;
                        rd_timeout_err <= 1'b1;
                        state          <= StIdle;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Accept strobes and read-data routing; suppressed while reset is held so
    // an abandoned transaction never completes towards a client.
    always_comb begin
        c0_wait_request_n = iRST_n && (state == StCmd) && avl_wait_request_n && (grant == 1'b0);
        c1_wait_request_n = iRST_n && (state == StCmd) && avl_wait_request_n && (grant == 1'b1);
        c0_readdatavalid  = iRST_n && (state == StRdWait) && avl_readdatavalid && (grant == 1'b0);
        c1_readdatavalid  = iRST_n && (state == StRdWait) && avl_readdatavalid && (grant == 1'b1);
        c0_readdata       = avl_readdata;
        c1_readdata       = avl_readdata;
        avl_burstbegin    = avl_read | avl_write;
        busy              = (state != StIdle);
    end

endmodule
